// File: rtl/mem_crossbar.sv
// mem_crossbar: NUM_MASTERS x NUM_SLAVES request/response crossbar with a round-robin arbiter per slave.
// Latency: requests are forwarded combinationally (0 cycles); responses are registered (1 cycle).
// Backpressure: a master stalls on slave ready, a full ID FIFO, its outstanding cap or a pending slave switch; responses have none.
module mem_crossbar #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_LSB     = 14,
  parameter int MAX_OUTST   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS-1:0]                 i_m_req_valid,
  output logic [NUM_MASTERS-1:0]                 o_m_req_ready,
  input  logic [NUM_MASTERS-1:0]                 i_m_we,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_m_wdata,
  output logic [NUM_MASTERS-1:0]                 o_m_rsp_valid,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] o_m_rsp_rdata,
  output logic [NUM_SLAVES-1:0]                  o_s_req_valid,
  input  logic [NUM_SLAVES-1:0]                  i_s_req_ready,
  output logic [NUM_SLAVES-1:0]                  o_s_we,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  o_s_addr,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  o_s_wdata,
  input  logic [NUM_SLAVES-1:0]                  i_s_rsp_valid,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  i_s_rsp_rdata,
  output logic                                   o_err
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  // Master-side state
  logic [NUM_MASTERS-1:0][SW-1:0]  sel;
  logic [NUM_MASTERS-1:0][CW-1:0]  cnt;
  logic [NUM_MASTERS-1:0][CW-1:0]  cnt_eff;
  logic [NUM_MASTERS-1:0][SW-1:0]  last_slave;
  logic [NUM_MASTERS-1:0]          dec_q;
  logic [NUM_MASTERS-1:0]          dec;
  logic [NUM_MASTERS-1:0]          m_rdy;

  // Slave-side state and arbitration
  logic [NUM_SLAVES-1:0][IW-1:0]   rr_ptr;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] elig;
  logic [NUM_SLAVES-1:0]           any_elig;
  logic [NUM_SLAVES-1:0][IW-1:0]   win;
  logic [NUM_SLAVES-1:0]           hs;
  logic [NUM_SLAVES-1:0]           room;

  // Per-slave ID FIFOs recording which master issued each outstanding request
  logic [IW-1:0]                   id_mem [NUM_SLAVES][MAX_OUTST];
  logic [NUM_SLAVES-1:0][PW-1:0]   wr_ptr;
  logic [NUM_SLAVES-1:0][PW-1:0]   rd_ptr;
  logic [NUM_SLAVES-1:0][CW-1:0]   f_cnt;
  logic [NUM_SLAVES-1:0]           f_empty;
  logic [NUM_SLAVES-1:0]           f_full;
  logic [NUM_SLAVES-1:0][IW-1:0]   f_head;
  logic [NUM_SLAVES-1:0]           f_push;

  // Response routing
  logic [NUM_SLAVES-1:0]           pop_q;
  logic [NUM_SLAVES-1:0]           bypass;
  logic [NUM_SLAVES-1:0]           spur;
  logic [NUM_SLAVES-1:0]           rsp_fire;
  logic [NUM_SLAVES-1:0][IW-1:0]   rsp_id;
  logic [NUM_MASTERS-1:0]                 rsp_vld_d;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rsp_dat_d;
  logic [NUM_MASTERS-1:0]                 rsp_vld_q;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rsp_dat_q;
  logic                                   err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) >= MAX_OUTST - 1) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] w);
    return (int'(w) >= NUM_MASTERS - 1) ? '0 : w + IW'(1);
  endfunction

  // Decode the target slave of every master from its address select field.
  always_comb begin
    sel = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      sel[m] = i_m_addr[m][SEL_LSB +: SW];
    end
  end

  // FIFO status and heads.
  always_comb begin
    f_empty = '0;
    f_full  = '0;
    f_head  = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      f_empty[s] = (f_cnt[s] == '0);
      f_full[s]  = (f_cnt[s] == CW'(MAX_OUTST));
      f_head[s]  = id_mem[s][rd_ptr[s]];
    end
  end

  // Responses that retire a stored entry; these free capacity for this cycle's arbitration.
  always_comb begin
    pop_q   = '0;
    dec_q   = '0;
    cnt_eff = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      pop_q[s] = rst_n && i_s_rsp_valid[s] && !f_empty[s];
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (pop_q[s] && f_head[s] == IW'(m)) dec_q[m] = 1'b1;
      end
    end
    for (int m = 0; m < NUM_MASTERS; m++) begin
      cnt_eff[m] = cnt[m] - CW'(dec_q[m]);
    end
  end

  // Eligibility: right slave, below the outstanding cap, no pending switch, FIFO space (counting a same-cycle pop).
  always_comb begin
    room = '0;
    elig = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      room[s] = !f_full[s] || pop_q[s];
      for (int m = 0; m < NUM_MASTERS; m++) begin
        elig[s][m] = rst_n && i_m_req_valid[m] && (sel[m] == SW'(s)) &&
                     (cnt_eff[m] < CW'(MAX_OUTST)) &&
                     ((cnt_eff[m] == '0) || (last_slave[m] == SW'(s))) && room[s];
      end
    end
  end

  // Round-robin pick per slave: first eligible master from rr_ptr upward, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    any_elig = '0;
    win      = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = int'(rr_ptr[s]) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (!any_elig[s] && elig[s][idx]) begin
          any_elig[s] = 1'b1;
          win[s]      = IW'(idx);
        end
      end
    end
  end

  // Forward the winner's request to each slave; idle slaves see all zeros.
  always_comb begin
    o_s_req_valid = any_elig;
    o_s_we        = '0;
    o_s_addr      = '0;
    o_s_wdata     = '0;
    hs            = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (any_elig[s]) begin
        o_s_we[s]    = i_m_we[win[s]];
        o_s_addr[s]  = i_m_addr[win[s]];
        o_s_wdata[s] = i_m_wdata[win[s]];
      end
      hs[s] = any_elig[s] && i_s_req_ready[s];
    end
  end

  // A master is accepted when it wins its slave and that slave is ready.
  always_comb begin
    m_rdy = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (hs[s] && win[s] == IW'(m)) m_rdy[m] = 1'b1;
      end
    end
  end

  assign o_m_req_ready = m_rdy;

  // Response classification: normal pop, flow-through on an empty FIFO being pushed, or spurious.
  always_comb begin
    bypass   = '0;
    spur     = '0;
    f_push   = '0;
    rsp_fire = '0;
    rsp_id   = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      bypass[s]   = rst_n && i_s_rsp_valid[s] && f_empty[s] && hs[s];
      spur[s]     = rst_n && i_s_rsp_valid[s] && f_empty[s] && !hs[s];
      f_push[s]   = hs[s] && !bypass[s];
      rsp_fire[s] = pop_q[s] || bypass[s];
      rsp_id[s]   = bypass[s] ? win[s] : f_head[s];
    end
  end

  // Steer each firing response to its issuing master; the single-slave rule keeps this one-hot per master.
  always_comb begin
    rsp_vld_d = '0;
    rsp_dat_d = '0;
    dec       = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (rsp_fire[s] && rsp_id[s] == IW'(m)) begin
          rsp_vld_d[m] = 1'b1;
          rsp_dat_d[m] = i_s_rsp_rdata[s];
          dec[m]       = 1'b1;
        end
      end
    end
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (f_push[s]) wr_ptr[s] <= ptr_inc(wr_ptr[s]);
        if (pop_q[s])  rd_ptr[s] <= ptr_inc(rd_ptr[s]);
        if (f_push[s] && !pop_q[s])      f_cnt[s] <= f_cnt[s] + CW'(1);
        else if (!f_push[s] && pop_q[s]) f_cnt[s] <= f_cnt[s] - CW'(1);
      end
    end
  end

  // ID FIFO storage; only entries between the pointers are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (f_push[s]) id_mem[s][wr_ptr[s]] <= win[s];
    end
  end

  // Round-robin pointers advance past the winner only on a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (hs[s]) rr_ptr[s] <= rr_next(win[s]);
      end
    end
  end

  // Per-master outstanding count and current target slave; simultaneous accept and response cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      last_slave <= '0;
    end else begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (m_rdy[m] && !dec[m])      cnt[m] <= cnt[m] + CW'(1);
        else if (!m_rdy[m] && dec[m]) cnt[m] <= cnt[m] - CW'(1);
        if (m_rdy[m]) last_slave[m] <= sel[m];
      end
    end
  end

  // Registered master responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  // Sticky error on any response that has no outstanding entry behind it.
  always_ff @(posedge clk) begin
    if (!rst_n)     err_q <= 1'b0;
    else if (|spur) err_q <= 1'b1;
  end

  // Registered outputs are masked while reset is held so nothing stale escapes before the first edge.
  assign o_m_rsp_valid = rst_n ? rsp_vld_q : '0;
  assign o_m_rsp_rdata = rst_n ? rsp_dat_q : '0;
  assign o_err         = rst_n && err_q;

endmodule

// File: tb/tb_mem_crossbar.sv
// tb_mem_crossbar: randomized and directed stimulus against a queue-based reference model.
// Latency: expects zero-cycle request acceptance and one-cycle response return.
// Backpressure: the bench plays the slaves, toggling ready and responding only to outstanding requests.
module tb_mem_crossbar;
  localparam int NM  = 2;
  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM-1:0]         m_vld, m_rdy, m_we, rsp_vld;
  logic [NM-1:0][AW-1:0] m_addr;
  logic [NM-1:0][DW-1:0] m_wdata, rsp_rdata;
  logic [NS-1:0]         s_vld, s_rdy, s_we, s_rsp;
  logic [NS-1:0][AW-1:0] s_addr;
  logic [NS-1:0][DW-1:0] s_wdata, s_rdata;
  logic                  err;

  always #5 clk = ~clk;

  mem_crossbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .SEL_LSB(14), .MAX_OUTST(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m_req_valid(m_vld), .o_m_req_ready(m_rdy), .i_m_we(m_we),
    .i_m_addr(m_addr), .i_m_wdata(m_wdata),
    .o_m_rsp_valid(rsp_vld), .o_m_rsp_rdata(rsp_rdata),
    .o_s_req_valid(s_vld), .i_s_req_ready(s_rdy), .o_s_we(s_we),
    .o_s_addr(s_addr), .o_s_wdata(s_wdata),
    .i_s_rsp_valid(s_rsp), .i_s_rsp_rdata(s_rdata),
    .o_err(err)
  );

  // Reference model: which master owns each slave's outstanding requests, in order.
  typedef struct { logic [DW-1:0] dat; int due; } ent_t;
  ent_t expq[NM][$];
  int   sq[NS][$];
  int   cnt_m[NM];
  int   last_m[NM];
  int   rr_s[NS];
  bit   exp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [NM-1:0]         seen_rdy, seen_rsp_vld;
  logic [NM-1:0][DW-1:0] seen_rsp_dat;
  logic                  seen_err;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every response must match the oldest pending entry in its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < NM; m++) begin
        bit due_now;
        due_now = (expq[m].size() > 0) && (expq[m][0].due == cyc);
        chk($sformatf("rsp_valid_m%0d", m), rsp_vld[m], due_now);
        if (due_now) begin
          chk($sformatf("rsp_rdata_m%0d", m), rsp_rdata[m], expq[m][0].dat);
          void'(expq[m].pop_front());
        end
      end
    end
  end

  function automatic int slave_of(input logic [AW-1:0] a);
    return int'((a / 32'h4000) % NS);
  endfunction

  function automatic bit busy();
    for (int s = 0; s < NS; s++) if (sq[s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: predict arbitration, compare at the falling edge, then advance the model.
  task automatic step();
    int pop_m[NM];
    bit popping[NS];
    bit room[NS];
    int win[NS];
    int eff[NM];
    int m;
    ent_t e;
    logic [NM-1:0]         e_rdy;
    logic [NS-1:0]         e_sv, e_we;
    logic [NS-1:0][AW-1:0] e_addr;
    logic [NS-1:0][DW-1:0] e_wd;
    e_rdy = '0; e_sv = '0; e_we = '0; e_addr = '0; e_wd = '0;
    for (int i = 0; i < NM; i++) pop_m[i] = 0;
    for (int s = 0; s < NS; s++) begin
      popping[s] = s_rsp[s] && (sq[s].size() > 0);
      if (popping[s]) pop_m[sq[s][0]]++;
      room[s] = (sq[s].size() - int'(popping[s])) < MAX;
    end
    for (int i = 0; i < NM; i++) eff[i] = cnt_m[i] - pop_m[i];
    for (int s = 0; s < NS; s++) begin
      win[s] = -1;
      for (int k = 0; k < NM; k++) begin
        m = (rr_s[s] + k) % NM;
        if (win[s] < 0 && m_vld[m] && slave_of(m_addr[m]) == s && eff[m] < MAX &&
            (eff[m] == 0 || last_m[m] == s) && room[s])
          win[s] = m;
      end
      if (win[s] >= 0) begin
        e_sv[s]   = 1'b1;
        e_we[s]   = m_we[win[s]];
        e_addr[s] = m_addr[win[s]];
        e_wd[s]   = m_wdata[win[s]];
        if (s_rdy[s]) e_rdy[win[s]] = 1'b1;
      end
    end
    @(negedge clk);
    seen_rdy = m_rdy; seen_rsp_vld = rsp_vld; seen_rsp_dat = rsp_rdata; seen_err = err;
    chk("m_req_ready", m_rdy, e_rdy);
    chk("s_req_valid", s_vld, e_sv);
    chk("s_we", s_we, e_we);
    chk("s_addr", s_addr, e_addr);
    chk("s_wdata", s_wdata, e_wd);
    chk("err", err, exp_err);
    for (int s = 0; s < NS; s++) begin
      if (s_rsp[s]) begin
        if (sq[s].size() > 0) begin
          m = sq[s].pop_front();
          cnt_m[m]--;
          e.dat = s_rdata[s];
          e.due = cyc + 1;
          expq[m].push_back(e);
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (win[s] >= 0 && s_rdy[s]) begin
        sq[s].push_back(win[s]);
        cnt_m[win[s]]++;
        last_m[win[s]] = s;
        rr_s[s] = (win[s] + 1) % NM;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_vld = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_rdy = '1; s_rsp = '0; s_rdata = '0;
  endtask

  task automatic rand_inputs(input bit with_spurious);
    m_vld = NM'($urandom);
    m_we  = NM'($urandom);
    for (int m = 0; m < NM; m++) begin
      m_addr[m]  = $urandom;
      m_wdata[m] = $urandom;
    end
    for (int s = 0; s < NS; s++) begin
      s_rdy[s]   = ($urandom_range(0, 3) != 0);
      s_rsp[s]   = with_spurious ? 1'($urandom) : ((sq[s].size() > 0) && ($urandom_range(0, 2) != 0));
      s_rdata[s] = $urandom;
    end
  endtask

  // Hold reset for two cycles under random inputs; every output must stay at zero.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rand_inputs(1'b1);
      @(negedge clk);
      chk("rst_m_req_ready", m_rdy, '0);
      chk("rst_m_rsp_valid", rsp_vld, '0);
      chk("rst_m_rsp_rdata", rsp_rdata, '0);
      chk("rst_s_req_valid", s_vld, '0);
      chk("rst_s_we", s_we, '0);
      chk("rst_s_addr", s_addr, '0);
      chk("rst_s_wdata", s_wdata, '0);
      chk("rst_err", err, '0);
      @(posedge clk);
      #1;
    end
    for (int m = 0; m < NM; m++) begin
      expq[m].delete();
      cnt_m[m] = 0;
      last_m[m] = 0;
    end
    for (int s = 0; s < NS; s++) begin
      sq[s].delete();
      rr_s[s] = 0;
    end
    exp_err = 1'b0;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  // Answer every outstanding request, then one quiet cycle so the last responses are observed.
  task automatic drain();
    int guard;
    guard = 0;
    m_vld = '0;
    s_rdy = '1;
    while (busy() && guard < 200) begin
      for (int s = 0; s < NS; s++) begin
        s_rsp[s]   = (sq[s].size() > 0);
        s_rdata[s] = $urandom;
      end
      step();
      guard++;
    end
    s_rsp = '0;
    step();
  endtask

  initial begin
    int g0, g1, left;
    exp_err = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Round robin on S2, with the first grant after reset going to M0.
    g0 = 0; g1 = 0;
    m_vld = 2'b11; m_we = '0;
    m_addr[0] = 32'h0000_8000; m_addr[1] = 32'h0000_8004;
    for (int c = 0; c < 8; c++) begin
      s_rsp = '0;
      s_rsp[2] = (sq[2].size() > 0);
      s_rdata[2] = $urandom;
      step();
      if (c == 0) chk("first_grant_m0", seen_rdy, 2'b01);
      chk($sformatf("rr_grant_c%0d", c), seen_rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (seen_rdy[0]) g0++;
      if (seen_rdy[1]) g1++;
    end
    chk("rr_m0_grants", g0, 4);
    chk("rr_m1_grants", g1, 4);
    drain();

    // Parallel reads to S0 and S1 in the same cycle.
    m_vld = 2'b11; m_we = '0;
    m_addr[0] = 32'h0000_0010; m_addr[1] = 32'h0000_4020;
    step();
    chk("par_ready", seen_rdy, 2'b11);
    m_vld = '0;
    s_rsp = 4'b0011; s_rdata[0] = 32'h0000_AAAA; s_rdata[1] = 32'h0000_BBBB;
    step();
    s_rsp = '0;
    step();
    chk("par_rsp_valid", seen_rsp_vld, 2'b11);
    chk("par_rsp_rdata", seen_rsp_dat, {32'h0000_BBBB, 32'h0000_AAAA});

    // Outstanding cap on S3: four accepted, fifth held until a response frees a slot.
    m_vld = 2'b01; m_addr[0] = 32'h0000_C000;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_req_c%0d", c), seen_rdy[0], (c < 4) ? 1'b1 : 1'b0);
    end
    s_rsp[3] = 1'b1; s_rdata[3] = $urandom;
    step();
    chk("bp_accept_on_pop", seen_rdy[0], 1'b1);
    s_rsp = '0;
    drain();

    // Slave switch: a request to S1 waits until the S0 transaction retires.
    m_vld = 2'b01; m_addr[0] = 32'h0000_0000;
    step();
    chk("sw_first", seen_rdy[0], 1'b1);
    m_addr[0] = 32'h0000_4000;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("sw_stall_c%0d", c), seen_rdy[0], 1'b0);
    end
    s_rsp[0] = 1'b1; s_rdata[0] = $urandom;
    step();
    chk("sw_accept", seen_rdy[0], 1'b1);
    s_rsp = '0;
    drain();

    // Spurious response on S1 sets a sticky error and reaches no master.
    s_rsp = 4'b0010; s_rdata[1] = 32'h1234_5678;
    step();
    s_rsp = '0;
    step();
    chk("spur_err", seen_err, 1'b1);
    chk("spur_no_rsp", seen_rsp_vld, '0);
    step();
    chk("spur_err_sticky", seen_err, 1'b1);

    // Random traffic with a reset in the middle of live transactions.
    for (int c = 0; c < 1500; c++) begin
      rand_inputs(1'b0);
      step();
      if (c == 700) do_reset();
    end
    drain();

    left = 0;
    for (int m = 0; m < NM; m++) left += expq[m].size();
    chk("scoreboard_left", left, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
